// File: rtl/key_event_reg.sv
// Synchronised, debounced key bank that queues press events (optionally release events) in a FWFT FIFO.
// Optional release reporting is enabled by defining KEY_EVENT_RELEASE_EVENTS_EN.
module key_event_reg #(
   parameter int unsigned N_KEYS          = 16,
   parameter int unsigned KEY_W           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned FIFO_DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_KEYS-1:0]             pressed,
   output logic [N_KEYS-1:0]             stable,
   output logic                          ev_valid,
   output logic [KEY_W-1:0]              ev_key,
   output logic                          ev_release,
   input  logic                          ev_ready,
   output logic [$clog2(FIFO_DEPTH):0]   ev_count,
   output logic                          overflow
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CW    = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_KEYS-1:0] s1_q, s2_q;
   logic [N_KEYS-1:0] stable_q, stable_d;
   logic [CNT_W-1:0]  cnt_q [N_KEYS];
   logic [CNT_W-1:0]  cnt_d [N_KEYS];
   logic [N_KEYS-1:0] rise;
   logic [N_KEYS-1:0] press_pend_q, press_pend_d, press_grant;
   logic              overflow_q, overflow_d;

   logic [KEY_W-1:0]  mem_key_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q, count_d;

   logic              pop, push, full, can_push;
   logic              sel_valid, sel_rel;
   logic [KEY_W-1:0]  sel_key;
   logic [N_KEYS-1:0] sel_oh;

`ifdef KEY_EVENT_RELEASE_EVENTS_EN
   logic [N_KEYS-1:0] fall;
   logic [N_KEYS-1:0] rel_pend_q, rel_pend_d, rel_grant;
   logic              mem_rel_q [FIFO_DEPTH];
`endif

   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < N_KEYS; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_MAX) stable_d[i] = ~stable_q[i];
            else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
      rise = stable_d & ~stable_q;

      pop      = ev_valid && ev_ready;
      full     = (count_q == CW'(FIFO_DEPTH));
      can_push = !full || pop;

      // Descending scan so the lowest index wins; press overrides release at the same index.
      sel_valid = 1'b0;
      sel_rel   = 1'b0;
      sel_key   = '0;
      sel_oh    = '0;
      for (int i = N_KEYS - 1; i >= 0; i--) begin
`ifdef KEY_EVENT_RELEASE_EVENTS_EN
         if (rel_pend_q[i]) begin
            sel_valid = 1'b1;
            sel_rel   = 1'b1;
            sel_key   = KEY_W'(i);
            sel_oh    = '0;
            sel_oh[i] = 1'b1;
         end
`endif
         if (press_pend_q[i]) begin
            sel_valid = 1'b1;
            sel_rel   = 1'b0;
            sel_key   = KEY_W'(i);
            sel_oh    = '0;
            sel_oh[i] = 1'b1;
         end
      end
      push = sel_valid && can_push;

      press_grant  = (push && !sel_rel) ? sel_oh : '0;
      press_pend_d = (press_pend_q & ~press_grant) | rise;
      overflow_d   = overflow_q | (|(press_pend_q & ~press_grant & rise));
`ifdef KEY_EVENT_RELEASE_EVENTS_EN
      fall       = ~stable_d & stable_q;
      rel_grant  = (push && sel_rel) ? sel_oh : '0;
      rel_pend_d = (rel_pend_q & ~rel_grant) | fall;
      overflow_d = overflow_d | (|(rel_pend_q & ~rel_grant & fall));
`endif

      count_d = count_q;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q         <= '0;
         s2_q         <= '0;
         stable_q     <= '0;
         press_pend_q <= '0;
         overflow_q   <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_key_q[i] <= '0;
      end else begin
         s1_q         <= pressed;
         s2_q         <= s1_q;
         stable_q     <= stable_d;
         press_pend_q <= press_pend_d;
         overflow_q   <= overflow_d;
         count_q      <= count_d;
         for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= cnt_d[i];
         if (push) begin
            mem_key_q[wr_ptr_q] <= sel_key;
            wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

`ifdef KEY_EVENT_RELEASE_EVENTS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rel_pend_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_rel_q[i] <= 1'b0;
      end else begin
         rel_pend_q <= rel_pend_d;
         if (push) mem_rel_q[wr_ptr_q] <= sel_rel;
      end
   end

   assign ev_release = mem_rel_q[rd_ptr_q];
`else
   assign ev_release = 1'b0;
`endif

   assign stable   = stable_q;
   assign ev_valid = (count_q != '0);
   assign ev_key   = mem_key_q[rd_ptr_q];
   assign ev_count = count_q;
   assign overflow = overflow_q;

endmodule

// File: doc/key_event_reg.md
Name: key_event_reg

Overview:
- Parametrised successor to the single-row key register.
- Synchronises and debounces N_KEYS raw key lines, then detects press edges.
- Serialises simultaneous presses by lowest index and buffers them as key-number events in a small FIFO.
- The game FSM consumes events with a valid/ready handshake, so no press is lost while it is busy.

Parameters:
- N_KEYS, 16, number of raw key inputs (1..32).
- KEY_W, 4, event key-number width; must satisfy 2**KEY_W >= N_KEYS.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles needed before a key changes state (>=1).
- FIFO_DEPTH, 4, event FIFO entries; power of two, >=2.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- pressed  in  N_KEYS  raw key lines, 1 = pressed, asynchronous to clk.
- stable  out  N_KEYS  debounced key state.
- ev_valid  out  1  FIFO head holds an event.
- ev_key  out  KEY_W  key number of the head event.
- ev_release  out  1  head event is a release; constant 0 unless RELEASE_EVENTS_EN.
- ev_ready  in  1  consumer accepts the head event this cycle.
- ev_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: an event was merged/lost.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset (async, immediate):
  - Synchroniser flops, stable, debounce counters and pending bitmaps cleared.
  - FIFO emptied: ev_valid=0, ev_count=0.
  - ev_key=0, ev_release=0, overflow=0.
  - Reset mid-operation discards all queued and pending events.
- Synchroniser: two flops per key; s2 is the synchronised value.
- Debounce, per key, counter width clog2(DEBOUNCE_CYCLES):
  - s2==stable: counter cleared.
  - s2!=stable and counter<DEBOUNCE_CYCLES-1: counter increments.
  - s2!=stable and counter==DEBOUNCE_CYCLES-1: stable toggles, counter cleared.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at s2 never changes stable.
- Edge detect: on the edge where stable[i] rises, press_pend[i] is set.
  - If press_pend[i] is already set, overflow is set and the events merge.
- Arbitration: each cycle, if the FIFO can accept, the lowest-index set pending bit is enqueued and cleared. At most one push per cycle.
- FIFO:
  - First-word-fall-through: ev_valid = (ev_count!=0); ev_key/ev_release show the head combinationally from storage.
  - Pop when ev_valid && ev_ready.
  - Push allowed when not full, or when full with a pop in the same cycle (occupancy unchanged).
  - When full with no pop, pending bits are held; nothing is dropped.
  - Pointers wrap modulo FIFO_DEPTH.
  - ev_ready while empty has no effect.
- Latency: pressed rising and held before clk edge 1 gives stable[i]=1 after edge DEBOUNCE_CYCLES+2, then ev_valid=1 after edge DEBOUNCE_CYCLES+3 (FIFO initially empty).
- overflow stays 1 until reset.

Optional Feature:
- Macro: KEY_EVENT_RELEASE_EVENTS_EN.
- Defined:
  - A falling edge of stable[i] sets rel_pend[i]; a re-set while pending sets overflow.
  - FIFO entries carry a release bit.
  - Arbitration picks the lowest index across both bitmaps; at equal index the press is enqueued before the release.
  - ev_release reports the head entry's bit.
- Undefined: no release logic or storage; ev_release tied 0.

Test Plan:
- Reset/idle: assert reset mid-stream with 3 queued events -> ev_valid=0, ev_count=0, stable=0, overflow=0 immediately, before the next clk edge.
- Single press, DEBOUNCE_CYCLES=4: pressed[5]=1 held from edge 1, ev_ready=0 -> stable[5] high after edge 6; ev_valid=1, ev_key=5 after edge 7; ev_ready pulse for one cycle -> ev_valid=0.
- Glitch rejection: pressed[2] high for 3 cycles then low -> stable stays 0, ev_valid never asserts.
- Simultaneous presses: pressed[9], [3], [12] rise together -> events 3, 9, 12 on consecutive cycles; ev_count reaches 3.
- Full/backpressure, FIFO_DEPTH=4: six distinct keys pressed, ev_ready=0 -> ev_count=4, two pending held, overflow=0. Then ev_ready=1 for 6 cycles -> all six keys pop in ascending order.
- Release option (macro defined): press then release key 7 -> events (7, release=0) then (7, release=1); without the macro only (7, 0).
